// File: rtl/enc_pwm_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : enc_pwm_pkg
// Brief   : Shared defaults, debounce length and step-direction type for
//           the encoder/PWM array.
// Revision: 1.0 - initial release
// ============================================================================
package enc_pwm_pkg;

  localparam int NUM_CH_DEF  = 3;
  localparam int WIDTH_DEF   = 8;
  localparam int STEP_DEF    = 1;
  localparam int DEB_DIV_DEF = 256;

  localparam int DEB_LEN = 3;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_e;

endpackage
`default_nettype wire

// File: rtl/enc_pwm_array_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : enc_pwm_array_if
// Brief   : Encoder inputs, preset controls and value/PWM outputs of the array.
// Revision: 1.0 - initial release
// ============================================================================
interface enc_pwm_array_if
  import enc_pwm_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int WIDTH  = WIDTH_DEF
);
  logic [NUM_CH-1:0]       enc_a;
  logic [NUM_CH-1:0]       enc_b;
  logic                    sat_mode;
  logic [NUM_CH-1:0]       load;
  logic [WIDTH-1:0]        load_val;
  logic [NUM_CH*WIDTH-1:0] value;
  logic [NUM_CH-1:0]       pwm;

  modport master (
    output enc_a, enc_b, sat_mode, load, load_val,
    input  value, pwm
  );

  modport slave (
    input  enc_a, enc_b, sat_mode, load, load_val,
    output value, pwm
  );
endinterface
`default_nettype wire

// File: rtl/enc_channel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : enc_channel
// Brief   : One encoder channel: sync, strobed debounce, x1 decode, step/load.
// Revision: 1.0 - initial release
// ============================================================================
module enc_channel
  import enc_pwm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP  = STEP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value
);
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  logic [1:0]         a_sync_q, a_sync_d, b_sync_q, b_sync_d;
  logic [DEB_LEN-1:0] a_hist_q, a_hist_d, b_hist_q, b_hist_d;
  logic               a_lvl_q, a_lvl_d, b_lvl_q, b_lvl_d;
  logic               a_prev_q, a_prev_d;
  logic [WIDTH-1:0]   value_q, value_d;
  logic [WIDTH:0]     sum, diff;
  dir_e               dir;

  always_comb begin
    a_sync_d = {a_sync_q[0], enc_a};
    b_sync_d = {b_sync_q[0], enc_b};
    a_hist_d = strobe ? {a_hist_q[DEB_LEN-2:0], a_sync_q[1]} : a_hist_q;
    b_hist_d = strobe ? {b_hist_q[DEB_LEN-2:0], b_sync_q[1]} : b_hist_q;

    // Level moves only on a unanimous history, so short glitches never land.
    a_lvl_d = a_lvl_q;
    if (&a_hist_q)       a_lvl_d = 1'b1;
    else if (~|a_hist_q) a_lvl_d = 1'b0;
    b_lvl_d = b_lvl_q;
    if (&b_hist_q)       b_lvl_d = 1'b1;
    else if (~|b_hist_q) b_lvl_d = 1'b0;

    a_prev_d = a_lvl_q;
    dir      = DIR_NONE;
    if (a_lvl_q && !a_prev_q) dir = b_lvl_q ? DIR_DN : DIR_UP;

    sum     = {1'b0, value_q} + STEP_X;
    diff    = {1'b0, value_q} - STEP_X;
    value_d = value_q;
    case (dir)
      DIR_UP:  value_d = (sat_mode && sum[WIDTH])  ? '1 : sum[WIDTH-1:0];
      DIR_DN:  value_d = (sat_mode && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
      default: value_d = value_q;
    endcase
    if (load) value_d = load_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      a_hist_q <= '0;
      b_hist_q <= '0;
      a_lvl_q  <= 1'b0;
      b_lvl_q  <= 1'b0;
      a_prev_q <= 1'b0;
      value_q  <= '0;
    end else begin
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
      a_hist_q <= a_hist_d;
      b_hist_q <= b_hist_d;
      a_lvl_q  <= a_lvl_d;
      b_lvl_q  <= b_lvl_d;
      a_prev_q <= a_prev_d;
      value_q  <= value_d;
    end
  end

  assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/enc_pwm_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : enc_pwm_array
// Brief   : NUM_CH encoder-driven duty values, each feeding a glitch-free PWM.
// Revision: 1.0 - initial release
// ============================================================================
module enc_pwm_array
  import enc_pwm_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int STEP    = STEP_DEF,
  parameter int DEB_DIV = DEB_DIV_DEF
) (
  input  logic          clk,
  input  logic          reset,
  enc_pwm_array_if.slave bus
);
  localparam int            PW       = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DEB_DIV - 1);

  logic [PW-1:0]           pre_q, pre_d;
  logic                    strobe;
  logic [WIDTH-1:0]        cnt_q, cnt_d;
  logic [NUM_CH*WIDTH-1:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0]       pwm_q, pwm_d;
  logic [NUM_CH*WIDTH-1:0] value_all;

  always_comb begin
    strobe   = (pre_q == PRE_LAST);
    pre_d    = strobe ? '0 : pre_q + PW'(1);
    cnt_d    = cnt_q + WIDTH'(1);
    // Duty is only picked up on the last count, so a period is never split.
    shadow_d = (&cnt_q) ? value_all : shadow_q;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = (cnt_q < shadow_q[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      pwm_q    <= '0;
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    enc_channel #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .strobe   (strobe),
      .enc_a    (bus.enc_a[i]),
      .enc_b    (bus.enc_b[i]),
      .sat_mode (bus.sat_mode),
      .load     (bus.load[i]),
      .load_val (bus.load_val),
      .value    (value_all[i*WIDTH +: WIDTH])
    );
  end

  assign bus.value = value_all;
  assign bus.pwm   = pwm_q;

endmodule
`default_nettype wire
